// File: rtl/axi_rw_master.sv
// Single-outstanding AXI4 initiator: one CPU load/store becomes one single-beat read or write.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_rw_master #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_STRB_WIDTH = 8,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rw_valid_i,
    output logic                      rw_ready_o,
    input  logic                      rw_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] rw_addr_i,
    input  logic [1:0]                rw_size_i,
    input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
    output logic                      rw_done_o,
    output logic [AXI_DATA_WIDTH-1:0] rw_r_data_o,
    output logic [1:0]                rw_resp_o,
    output logic                      rw_timeout_o,
    input  logic                      axi_aw_ready_i,
    output logic                      axi_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_o,
    output logic [2:0]                axi_aw_prot_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user_o,
    output logic [7:0]                axi_aw_len_o,
    output logic [2:0]                axi_aw_size_o,
    output logic [1:0]                axi_aw_burst_o,
    output logic                      axi_aw_lock_o,
    output logic [3:0]                axi_aw_cache_o,
    output logic [3:0]                axi_aw_qos_o,
    output logic [3:0]                axi_aw_region_o,
    input  logic                      axi_w_ready_i,
    output logic                      axi_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb_o,
    output logic                      axi_w_last_o,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user_o,
    output logic                      axi_b_ready_o,
    input  logic                      axi_b_valid_i,
    input  logic [1:0]                axi_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user_i,
    input  logic                      axi_ar_ready_i,
    output logic                      axi_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
    output logic [2:0]                axi_ar_prot_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user_o,
    output logic [7:0]                axi_ar_len_o,
    output logic [2:0]                axi_ar_size_o,
    output logic [1:0]                axi_ar_burst_o,
    output logic                      axi_ar_lock_o,
    output logic [3:0]                axi_ar_cache_o,
    output logic [3:0]                axi_ar_qos_o,
    output logic [3:0]                axi_ar_region_o,
    output logic                      axi_r_ready_o,
    input  logic                      axi_r_valid_i,
    input  logic [1:0]                axi_r_resp_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
    input  logic                      axi_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user_i
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE} state_e;

    state_e                    state_q, state_d;
    logic                      req_q, req_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]                size_q, size_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      done_q, done_d;
    logic                      misaligned;
    logic [AXI_DATA_WIDTH-1:0] r_shifted;
    logic [AXI_DATA_WIDTH-1:0] load_data;
    logic [7:0]                strb_base;

    logic unused_inputs;
    assign unused_inputs = ^{axi_r_id_i, axi_r_user_i, axi_b_id_i, axi_b_user_i};

    always_comb begin
        case (rw_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = rw_addr_i[0];
            2'd2:    misaligned = |rw_addr_i[1:0];
            default: misaligned = |rw_addr_i[2:0];
        endcase
    end

    always_comb begin
        r_shifted = axi_r_data_i >> {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0:    load_data = {56'd0, r_shifted[7:0]};
            2'd1:    load_data = {48'd0, r_shifted[15:0]};
            2'd2:    load_data = {32'd0, r_shifted[31:0]};
            default: load_data = r_shifted;
        endcase
        case (size_q)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rw_valid_i) begin
                if (misaligned)    state_d = DONE;
                else if (rw_req_i) state_d = WR_AW_W;
                else               state_d = RD_AR;
            end
            RD_AR:   if (axi_ar_ready_i) state_d = RD_R;
            RD_R:    if (axi_r_valid_i && axi_r_last_i) state_d = DONE;
            // AW and W complete independently; either may handshake first
            WR_AW_W: if ((aw_done_q || axi_aw_ready_i) && (w_done_q || axi_w_ready_i)) state_d = WR_B;
            WR_B:    if (axi_b_valid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        rw_ready_o     = (state_q == IDLE);
        axi_ar_valid_o = (state_q == RD_AR);
        axi_r_ready_o  = (state_q == RD_R);
        axi_aw_valid_o = (state_q == WR_AW_W) && !aw_done_q;
        axi_w_valid_o  = (state_q == WR_AW_W) && !w_done_q;
        axi_b_ready_o  = (state_q == WR_B);
    end

    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        done_d    = (state_q == DONE);
        case (state_q)
            IDLE: if (rw_valid_i) begin
                req_d     = rw_req_i;
                addr_d    = rw_addr_i;
                size_d    = rw_size_i;
                data_d    = rw_w_data_i;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (misaligned) begin
                    rdata_d = '0;
                    resp_d  = 2'b10;
                end
            end
            RD_R: if (axi_r_valid_i && axi_r_last_i) begin
                rdata_d = load_data;
                resp_d  = axi_r_resp_i;
            end
            WR_AW_W: begin
                aw_done_d = aw_done_q | axi_aw_ready_i;
                w_done_d  = w_done_q | axi_w_ready_i;
            end
            WR_B: if (axi_b_valid_i) begin
                rdata_d = '0;
                resp_d  = axi_b_resp_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            data_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            data_q    <= data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
        end
    end

    logic unused_req;
    assign unused_req = req_q;

    assign rw_done_o   = done_q;
    assign rw_r_data_o = rdata_q;
    assign rw_resp_o   = resp_q;

    assign axi_aw_addr_o   = addr_q;
    assign axi_aw_prot_o   = 3'b000;
    assign axi_aw_id_o     = '0;
    assign axi_aw_user_o   = '0;
    assign axi_aw_len_o    = '0;
    assign axi_aw_size_o   = {1'b0, size_q};
    assign axi_aw_burst_o  = 2'b01;
    assign axi_aw_lock_o   = 1'b0;
    assign axi_aw_cache_o  = 4'b0010;
    assign axi_aw_qos_o    = '0;
    assign axi_aw_region_o = '0;
    assign axi_w_data_o    = data_q << {addr_q[2:0], 3'b000};
    assign axi_w_strb_o    = strb_base << addr_q[2:0];
    assign axi_w_last_o    = 1'b1;
    assign axi_w_user_o    = '0;
    assign axi_ar_addr_o   = addr_q;
    assign axi_ar_prot_o   = 3'b000;
    assign axi_ar_id_o     = '0;
    assign axi_ar_user_o   = '0;
    assign axi_ar_len_o    = '0;
    assign axi_ar_size_o   = {1'b0, size_q};
    assign axi_ar_burst_o  = 2'b01;
    assign axi_ar_lock_o   = 1'b0;
    assign axi_ar_cache_o  = 4'b0010;
    assign axi_ar_qos_o    = '0;
    assign axi_ar_region_o = '0;

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q inside {RD_AR, RD_R, WR_AW_W, WR_B}) && (cnt_q != '1))
            cnt_d = cnt_q + 16'd1;
        timeout_d = timeout_q | (cnt_d >= 16'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign rw_timeout_o = timeout_q;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign rw_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rw_master.sv
// Bench for axi_rw_master: directed and randomized load/store traffic against an
// in-bench AXI responder, with expectations computed from byte-lane arithmetic.
module tb_axi_rw_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rw_valid_i, rw_ready_o, rw_req_i;
    logic [63:0] rw_addr_i;
    logic [1:0]  rw_size_i;
    logic [63:0] rw_w_data_i;
    logic        rw_done_o;
    logic [63:0] rw_r_data_o;
    logic [1:0]  rw_resp_o;
    logic        rw_timeout_o;
    logic        axi_aw_ready_i, axi_aw_valid_o;
    logic [63:0] axi_aw_addr_o;
    logic [2:0]  axi_aw_prot_o;
    logic [3:0]  axi_aw_id_o;
    logic [0:0]  axi_aw_user_o;
    logic [7:0]  axi_aw_len_o;
    logic [2:0]  axi_aw_size_o;
    logic [1:0]  axi_aw_burst_o;
    logic        axi_aw_lock_o;
    logic [3:0]  axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o;
    logic        axi_w_ready_i, axi_w_valid_o;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_w_last_o;
    logic [0:0]  axi_w_user_o;
    logic        axi_b_ready_o, axi_b_valid_i;
    logic [1:0]  axi_b_resp_i;
    logic [3:0]  axi_b_id_i;
    logic [0:0]  axi_b_user_i;
    logic        axi_ar_ready_i, axi_ar_valid_o;
    logic [63:0] axi_ar_addr_o;
    logic [2:0]  axi_ar_prot_o;
    logic [3:0]  axi_ar_id_o;
    logic [0:0]  axi_ar_user_o;
    logic [7:0]  axi_ar_len_o;
    logic [2:0]  axi_ar_size_o;
    logic [1:0]  axi_ar_burst_o;
    logic        axi_ar_lock_o;
    logic [3:0]  axi_ar_cache_o, axi_ar_qos_o, axi_ar_region_o;
    logic        axi_r_ready_o, axi_r_valid_i;
    logic [1:0]  axi_r_resp_i;
    logic [63:0] axi_r_data_i;
    logic        axi_r_last_i;
    logic [3:0]  axi_r_id_i;
    logic [0:0]  axi_r_user_i;

    int checks = 0;
    int errors = 0;

    // Observations recorded by the transaction driver
    int          obs_done, obs_lat, obs_ar_cycles, obs_aw_cycles, obs_w_cycles, obs_drop;
    int          obs_done_after, obs_ready_after, obs_attr_bad;
    logic [63:0] obs_rdata, obs_ar_addr, obs_aw_addr, obs_w_data;
    logic [1:0]  obs_resp;
    logic [2:0]  obs_ar_size, obs_aw_size;
    logic [7:0]  obs_w_strb, obs_aw_len;
    logic        obs_w_last;

    axi_rw_master #(
        .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(64), .AXI_ID_WIDTH(4),
        .AXI_STRB_WIDTH(8), .AXI_USER_WIDTH(1), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rw_valid_i(rw_valid_i), .rw_ready_o(rw_ready_o), .rw_req_i(rw_req_i),
        .rw_addr_i(rw_addr_i), .rw_size_i(rw_size_i), .rw_w_data_i(rw_w_data_i),
        .rw_done_o(rw_done_o), .rw_r_data_o(rw_r_data_o), .rw_resp_o(rw_resp_o),
        .rw_timeout_o(rw_timeout_o),
        .axi_aw_ready_i(axi_aw_ready_i), .axi_aw_valid_o(axi_aw_valid_o),
        .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_prot_o(axi_aw_prot_o),
        .axi_aw_id_o(axi_aw_id_o), .axi_aw_user_o(axi_aw_user_o),
        .axi_aw_len_o(axi_aw_len_o), .axi_aw_size_o(axi_aw_size_o),
        .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_lock_o(axi_aw_lock_o),
        .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_qos_o(axi_aw_qos_o),
        .axi_aw_region_o(axi_aw_region_o),
        .axi_w_ready_i(axi_w_ready_i), .axi_w_valid_o(axi_w_valid_o),
        .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
        .axi_w_last_o(axi_w_last_o), .axi_w_user_o(axi_w_user_o),
        .axi_b_ready_o(axi_b_ready_o), .axi_b_valid_i(axi_b_valid_i),
        .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i), .axi_b_user_i(axi_b_user_i),
        .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_valid_o(axi_ar_valid_o),
        .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_prot_o(axi_ar_prot_o),
        .axi_ar_id_o(axi_ar_id_o), .axi_ar_user_o(axi_ar_user_o),
        .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_lock_o(axi_ar_lock_o),
        .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_qos_o(axi_ar_qos_o),
        .axi_ar_region_o(axi_ar_region_o),
        .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
        .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i),
        .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i), .axi_r_user_i(axi_r_user_i)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    // Reference: a load returns the addressed bytes packed to bit 0, zero above
    function automatic logic [63:0] ref_load(input logic [63:0] word, input int off, input int nbytes);
        logic [63:0] r = '0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] ref_strb(input int off, input int nbytes);
        logic [7:0] s = '0;
        for (int i = 0; i < nbytes; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    task automatic slave_idle();
        axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_ar_ready_i = 0;
        axi_b_valid_i = 0;  axi_r_valid_i = 0; axi_r_last_i = 0;
    endtask

    task automatic run_txn(input logic req, input logic [63:0] addr, input logic [1:0] size,
                           input logic [63:0] wdata, input logic [63:0] rword, input logic [1:0] sresp,
                           input int ar_wait, input int aw_wait, input int w_wait,
                           input int r_wait, input int b_wait, input int junk);
        int cyc = 1, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0, junk_left = junk;
        logic ar_pend = 0, aw_pend = 0, w_pend = 0;
        obs_done = 0; obs_lat = -1; obs_ar_cycles = 0; obs_aw_cycles = 0; obs_w_cycles = 0;
        obs_drop = 0; obs_attr_bad = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && !rw_ready_o; i++) @(negedge clk);
        rw_valid_i = 1; rw_req_i = req; rw_addr_i = addr; rw_size_i = size; rw_w_data_i = wdata;
        @(negedge clk);
        rw_valid_i = 0; rw_addr_i = {$urandom, $urandom}; rw_w_data_i = {$urandom, $urandom};
        rw_size_i = 2'($urandom); rw_req_i = 1'($urandom);
        while (cyc <= 300 && obs_done == 0) begin
            if ((ar_pend && (!axi_ar_valid_o || axi_ar_addr_o !== obs_ar_addr)) ||
                (aw_pend && (!axi_aw_valid_o || axi_aw_addr_o !== obs_aw_addr)) ||
                (w_pend && (!axi_w_valid_o || axi_w_data_o !== obs_w_data))) obs_drop = 1;
            if (axi_ar_valid_o) begin
                obs_ar_cycles++;
                if (obs_ar_cycles == 1) begin obs_ar_addr = axi_ar_addr_o; obs_ar_size = axi_ar_size_o; end
                if (axi_ar_len_o !== 8'd0 || axi_ar_burst_o !== 2'b01 || axi_ar_cache_o !== 4'b0010 ||
                    axi_ar_id_o !== 4'd0 || axi_ar_prot_o !== 3'd0) obs_attr_bad = 1;
                axi_ar_ready_i = (ar_cnt >= ar_wait); ar_cnt++;
            end else axi_ar_ready_i = 0;
            ar_pend = axi_ar_valid_o && !axi_ar_ready_i;
            if (axi_aw_valid_o) begin
                obs_aw_cycles++;
                if (obs_aw_cycles == 1) begin
                    obs_aw_addr = axi_aw_addr_o; obs_aw_size = axi_aw_size_o; obs_aw_len = axi_aw_len_o;
                end
                if (axi_aw_burst_o !== 2'b01 || axi_aw_cache_o !== 4'b0010 || axi_aw_id_o !== 4'd0) obs_attr_bad = 1;
                axi_aw_ready_i = (aw_cnt >= aw_wait); aw_cnt++;
            end else axi_aw_ready_i = 0;
            aw_pend = axi_aw_valid_o && !axi_aw_ready_i;
            if (axi_w_valid_o) begin
                obs_w_cycles++;
                if (obs_w_cycles == 1) begin
                    obs_w_data = axi_w_data_o; obs_w_strb = axi_w_strb_o; obs_w_last = axi_w_last_o;
                end
                axi_w_ready_i = (w_cnt >= w_wait); w_cnt++;
            end else axi_w_ready_i = 0;
            w_pend = axi_w_valid_o && !axi_w_ready_i;
            if (axi_r_ready_o) begin
                if (r_cnt < r_wait) axi_r_valid_i = 0;
                else if (junk_left > 0) begin
                    axi_r_valid_i = 1; axi_r_last_i = 0; axi_r_data_i = {$urandom, $urandom};
                    axi_r_resp_i = 2'($urandom); junk_left--;
                end else begin
                    axi_r_valid_i = 1; axi_r_last_i = 1; axi_r_data_i = rword; axi_r_resp_i = sresp;
                end
                r_cnt++;
            end else axi_r_valid_i = 0;
            if (axi_b_ready_o) begin
                axi_b_valid_i = (b_cnt >= b_wait); axi_b_resp_i = sresp; b_cnt++;
            end else axi_b_valid_i = 0;
            if (rw_done_o) begin
                obs_done = 1; obs_lat = cyc; obs_rdata = rw_r_data_o; obs_resp = rw_resp_o;
            end
            @(negedge clk);
            cyc++;
        end
        slave_idle();
        obs_done_after = int'(rw_done_o);
        obs_ready_after = int'(rw_ready_o);
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++; if (rw_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", rw_done_o); end
        checks++; if ({axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o, axi_r_ready_o, axi_b_ready_o} !== 5'b0) begin
            errors++; $display("FAIL reset_handshakes: got %b expected 00000",
                {axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o, axi_r_ready_o, axi_b_ready_o}); end
        checks++; if (rw_r_data_o !== 64'd0 || rw_resp_o !== 2'd0) begin errors++;
            $display("FAIL reset_rdata_resp: got %h/%0d expected 0/0", rw_r_data_o, rw_resp_o); end
        checks++; if (axi_ar_addr_o !== 64'd0 || axi_w_data_o !== 64'd0) begin errors++;
            $display("FAIL reset_regs: got addr %h wdata %h expected 0", axi_ar_addr_o, axi_w_data_o); end
        checks++; if (rw_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", rw_timeout_o); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (rw_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rw_ready_o); end
    endtask

    task automatic test_read_dword();
        run_txn(0, 64'h8000_0000, 2'd3, 64'd0, 64'h1122334455667788, 2'd0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs_done !== 1) begin errors++; $display("FAIL rd_done_seen: got %0d expected 1", obs_done); end
        checks++; if (obs_lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", obs_lat); end
        checks++; if (obs_ar_addr !== 64'h8000_0000) begin errors++; $display("FAIL rd_ar_addr: got %h expected 80000000", obs_ar_addr); end
        checks++; if (obs_ar_size !== 3'd3) begin errors++; $display("FAIL rd_ar_size: got %0d expected 3", obs_ar_size); end
        checks++; if (obs_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data: got %h expected 1122334455667788", obs_rdata); end
        checks++; if (obs_attr_bad !== 0) begin errors++; $display("FAIL rd_attrs: got bad=%0d expected 0", obs_attr_bad); end
        checks++; if (obs_done_after !== 0 || obs_ready_after !== 1) begin errors++;
            $display("FAIL rd_single_pulse: got done=%0d ready=%0d expected 0/1", obs_done_after, obs_ready_after); end
    endtask

    task automatic test_write_byte();
        run_txn(1, 64'h8000_0005, 2'd0, 64'hAB, 64'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs_w_strb !== 8'b0010_0000) begin errors++; $display("FAIL wr_strb: got %b expected 00100000", obs_w_strb); end
        checks++; if (obs_w_data[47:40] !== 8'hAB) begin errors++; $display("FAIL wr_lane: got %h expected ab", obs_w_data[47:40]); end
        checks++; if (obs_aw_len !== 8'd0 || obs_w_last !== 1'b1) begin errors++;
            $display("FAIL wr_len_last: got len %0d last %b expected 0/1", obs_aw_len, obs_w_last); end
        checks++; if (obs_done !== 1 || obs_lat !== 4 || obs_resp !== 2'd0) begin errors++;
            $display("FAIL wr_done: got done=%0d lat=%0d resp=%0d expected 1/4/0", obs_done, obs_lat, obs_resp); end
    endtask

    task automatic test_aw_stall();
        run_txn(1, 64'h8000_0010, 2'd2, 64'hDEADBEEF, 64'd0, 2'd0, 0, 5, 0, 0, 0, 0);
        checks++; if (obs_w_cycles !== 1) begin errors++; $display("FAIL stall_w_cycles: got %0d expected 1", obs_w_cycles); end
        checks++; if (obs_aw_cycles !== 6) begin errors++; $display("FAIL stall_aw_cycles: got %0d expected 6", obs_aw_cycles); end
        checks++; if (obs_lat !== 9 || obs_done_after !== 0) begin errors++;
            $display("FAIL stall_done: got lat=%0d after=%0d expected 9/0", obs_lat, obs_done_after); end
        checks++; if (obs_drop !== 0) begin errors++; $display("FAIL stall_valid_stable: got drop=%0d expected 0", obs_drop); end
    endtask

    task automatic test_misaligned();
        run_txn(0, 64'h8000_0003, 2'd1, 64'd0, 64'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs_ar_cycles !== 0) begin errors++; $display("FAIL mis_no_ar: got %0d cycles expected 0", obs_ar_cycles); end
        checks++; if (obs_lat !== 2 || obs_resp !== 2'b10) begin errors++;
            $display("FAIL mis_done: got lat=%0d resp=%0d expected 2/2", obs_lat, obs_resp); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        axi_ar_ready_i = 1;
        rw_valid_i = 1; rw_req_i = 0; rw_addr_i = 64'h8000_0040; rw_size_i = 2'd3;
        @(negedge clk);
        rw_valid_i = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (axi_r_ready_o) seen = 1; else @(negedge clk);
        end
        axi_ar_ready_i = 0;
        checks++; if (seen !== 1) begin errors++; $display("FAIL rstmid_reach_r: got %0d expected 1", seen); end
        #2 rst_n = 0;
        #1;
        checks++; if (axi_r_ready_o !== 1'b0 || axi_ar_valid_o !== 1'b0) begin errors++;
            $display("FAIL rstmid_drop: got r_ready=%b ar_valid=%b expected 0/0", axi_r_ready_o, axi_ar_valid_o); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (rw_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", rw_ready_o); end
        run_txn(0, 64'h8000_0044, 2'd2, 64'd0, 64'hCAFEF00D_12345678, 2'd0, 1, 0, 0, 1, 0, 0);
        checks++; if (obs_rdata !== 64'h0000_0000_CAFEF00D || obs_lat !== 6) begin errors++;
            $display("FAIL rstmid_next: got %h lat=%0d expected 00000000cafef00d lat=6", obs_rdata, obs_lat); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        req = 1'($urandom);
            logic [1:0]  size = 2'($urandom);
            int          nb = 1 << size;
            int          off = ($urandom % 5 == 0) ? int'($urandom % 8) : int'($urandom % (8 / nb)) * nb;
            logic [63:0] addr = ({$urandom, $urandom} & ~64'h7) | 64'(off);
            logic [63:0] wdata = {$urandom, $urandom};
            logic [63:0] rword = {$urandom, $urandom};
            logic [1:0]  sresp = 2'($urandom);
            int aw_w = $urandom % 4, w_w = $urandom % 4, ar_w = $urandom % 4;
            int r_w = $urandom % 4, b_w = $urandom % 4, junk = $urandom % 2;
            int mis = (off % nb) != 0;
            int exp_lat = mis ? 2 : (req ? 4 + ((aw_w > w_w) ? aw_w : w_w) + b_w : 4 + ar_w + r_w + junk);
            run_txn(req, addr, size, wdata, rword, sresp, ar_w, aw_w, w_w, r_w, b_w, junk);
            checks++; if (obs_done !== 1 || obs_lat !== exp_lat || obs_done_after !== 0) begin errors++;
                $display("FAIL rnd%0d_timing: got done=%0d lat=%0d after=%0d expected 1/%0d/0", t, obs_done, obs_lat, obs_done_after, exp_lat); end
            checks++; if (obs_resp !== (mis ? 2'b10 : sresp)) begin errors++;
                $display("FAIL rnd%0d_resp: got %0d expected %0d", t, obs_resp, mis ? 2'b10 : sresp); end
            checks++; if (obs_drop !== 0 || obs_attr_bad !== 0) begin errors++;
                $display("FAIL rnd%0d_axi_rules: got drop=%0d attr=%0d expected 0/0", t, obs_drop, obs_attr_bad); end
            if (mis) begin
                checks++; if (obs_ar_cycles + obs_aw_cycles + obs_w_cycles !== 0) begin errors++;
                    $display("FAIL rnd%0d_mis_traffic: got %0d valid cycles expected 0", t, obs_ar_cycles + obs_aw_cycles + obs_w_cycles); end
            end else if (!req) begin
                checks++; if (obs_rdata !== ref_load(rword, off, nb)) begin errors++;
                    $display("FAIL rnd%0d_rdata: got %h expected %h", t, obs_rdata, ref_load(rword, off, nb)); end
                checks++; if (obs_ar_addr !== addr || obs_ar_size !== {1'b0, size} || obs_ar_cycles !== ar_w + 1) begin errors++;
                    $display("FAIL rnd%0d_ar: got %h/%0d/%0d expected %h/%0d/%0d", t, obs_ar_addr, obs_ar_size, obs_ar_cycles, addr, size, ar_w + 1); end
            end else begin
                checks++; if (obs_w_strb !== ref_strb(off, nb) || obs_w_data !== (wdata << (8 * off))) begin errors++;
                    $display("FAIL rnd%0d_wbeat: got %b/%h expected %b/%h", t, obs_w_strb, obs_w_data, ref_strb(off, nb), wdata << (8 * off)); end
                checks++; if (obs_aw_addr !== addr || obs_aw_size !== {1'b0, size} || obs_aw_cycles !== aw_w + 1 || obs_w_cycles !== w_w + 1) begin errors++;
                    $display("FAIL rnd%0d_aw: got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d", t, obs_aw_addr, obs_aw_size, obs_aw_cycles, obs_w_cycles, addr, size, aw_w + 1, w_w + 1); end
            end
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int first = -1, rise = -1;
        @(negedge clk);
        rw_valid_i = 1; rw_req_i = 0; rw_addr_i = 64'h8000_0100; rw_size_i = 2'd3;
        @(negedge clk);
        rw_valid_i = 0;
        for (int c = 0; c < 1200 && rise < 0; c++) begin
            if (axi_ar_valid_o && first < 0) first = c;
            if (rw_timeout_o) rise = c;
            else @(negedge clk);
        end
        checks++; if (rise - first !== 1024) begin errors++; $display("FAIL timeout_delay: got %0d expected 1024", rise - first); end
        checks++; if (axi_ar_valid_o !== 1'b1) begin errors++; $display("FAIL timeout_ar_held: got %b expected 1", axi_ar_valid_o); end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask
`endif

    initial begin
        rw_valid_i = 0; rw_req_i = 0; rw_addr_i = '0; rw_size_i = '0; rw_w_data_i = '0;
        axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_ar_ready_i = 0;
        axi_b_valid_i = 0; axi_b_resp_i = '0; axi_b_id_i = '0; axi_b_user_i = '0;
        axi_r_valid_i = 0; axi_r_resp_i = '0; axi_r_data_i = '0; axi_r_last_i = 0;
        axi_r_id_i = '0; axi_r_user_i = '0;
        test_reset();
        test_read_dword();
        test_write_byte();
        test_aw_stall();
        test_misaligned();
        test_reset_mid();
        test_random();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rw_master.md
Name: axi_rw_master

Overview:
- CPU-side AXI4 initiator. Converts single CPU load/store requests into single-beat AXI4 read or write transactions.
- It is the master end of the AXI interface whose slave side is axi_slave_if. It sits inside rvcpu and drives the axi_* ports.
- One transaction is outstanding at a time. Byte-lane alignment is done in both directions.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width (only 64 is supported).
- AXI_ADDR_WIDTH, 64, address width.
- AXI_ID_WIDTH, 4, ID width; all IDs are driven to 0.
- AXI_STRB_WIDTH, 8, write strobe width.
- AXI_USER_WIDTH, 1, user width; driven to 0.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rw_valid_i  input  1  CPU request valid
- rw_ready_o  output  1  request accepted when valid&&ready; high only in IDLE
- rw_req_i  input  1  0 = read, 1 = write
- rw_addr_i  input  AXI_ADDR_WIDTH  byte address
- rw_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = dword
- rw_w_data_i  input  64  store data, right-aligned
- rw_done_o  output  1  one-cycle completion pulse
- rw_r_data_o  output  64  load data, right-aligned, zero-extended; valid with rw_done_o
- rw_resp_o  output  2  AXI response code; valid with rw_done_o
- rw_timeout_o  output  1  sticky watchdog flag
- axi_aw_valid_o/axi_aw_ready_i, axi_w_valid_o/axi_w_ready_i, axi_b_valid_i/axi_b_ready_o, axi_ar_valid_o/axi_ar_ready_i, axi_r_valid_i/axi_r_ready_o  1 each  AXI handshakes
- axi_aw_addr_o, axi_ar_addr_o  output  AXI_ADDR_WIDTH  captured address
- axi_w_data_o  output  64; axi_w_strb_o  output  8; axi_w_last_o  output  1
- axi_r_data_i  input  64; axi_r_resp_i  input  2; axi_r_last_i  input  1; axi_b_resp_i  input  2
- axi_{aw,ar}_{id,len,size,burst,lock,cache,prot,qos,region,user}_o, axi_w_user_o  output  various  fixed attributes: id 0, len 0, size = rw_size_i, burst 2'b01, lock 0, cache 4'b0010, prot 3'b000, qos 0, region 0, user 0
- axi_r_id_i, axi_r_user_i, axi_b_id_i, axi_b_user_i  input  various  ignored

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; the request cannot be lost partially.
  - All *_valid_o, *_ready_o except rw_ready_o, rw_done_o and rw_timeout_o go to 0.
  - rw_r_data_o and rw_resp_o go to 0. Address and data registers go to 0.
  - rw_ready_o is 1 once out of reset.
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE: on rw_valid_i && rw_ready_o, capture addr, size, data and req.
  - Go to RD_AR (read) or WR_AW_W (write). axi_*_valid_o rises on the next cycle.
  - Misaligned request (addr[2:0] not a multiple of 1<<size): no AXI traffic. Go to DONE with resp 2'b10.
- RD_AR: axi_ar_valid_o=1, held with stable address until axi_ar_ready_i. Then go to RD_R.
- RD_R: axi_r_ready_o=1.
  - On r_valid && r_last: capture (r_data >> 8*addr[2:0]) masked to size, plus r_resp. Go to DONE.
  - A beat with r_valid && !r_last is consumed and ignored.
- WR_AW_W:
  - axi_aw_valid_o and axi_w_valid_o are asserted together; each drops independently after its own handshake.
  - w_data = data << 8*addr[2:0]; w_strb = ((1<<(1<<size))-1) << addr[2:0]; w_last=1.
  - When both have handshaken (same or different cycles), go to WR_B.
- WR_B: axi_b_ready_o=1. On b_valid, capture b_resp. Go to DONE.
- DONE: rw_done_o=1 for exactly one cycle, then IDLE.
  - rw_ready_o is 0 outside IDLE, so no back-to-back acceptance in the DONE cycle.
- Minimum read latency (accept to done pulse), with ready/valid returned in the same cycle as issue: 4 cycles. Same for writes.
- Valid signals never drop before their handshake. Outputs do not depend combinationally on AXI inputs except through registers.

Optional Feature:
- Macro AXI_MASTER_TIMEOUT_EN.
- When defined: a 16-bit counter clears on every state change and increments while in RD_AR, RD_R, WR_AW_W or WR_B.
  - Reaching TIMEOUT_CYCLES sets rw_timeout_o, sticky until reset.
  - The transaction still waits; AXI rules are preserved.
- When undefined: no counter is built; rw_timeout_o is tied 0.

Test Plan:
- Read dword at 0x8000_0000, slave returns r_data 0x1122334455667788 resp 0 after 0 wait → ar_addr 0x8000_0000, ar_size 3; rw_done_o 4 cycles after accept; rw_r_data_o 0x1122334455667788.
- Write byte 0xAB to 0x8000_0005 → w_strb 8'b0010_0000, w_data[47:40]=0xAB, aw_len 0, w_last 1; done after b_valid, resp 0.
- Slave holds aw_ready low 5 cycles while w_ready is immediate → w_valid drops after 1 cycle, aw_valid stays high 6 cycles; single done pulse.
- Half read at 0x8000_0003 (misaligned) → no ar_valid; rw_done_o with resp 2'b10 two cycles after accept.
- Assert rst_n=0 while in RD_R → axi_r_ready_o and axi_ar_valid_o fall immediately; rw_ready_o is 1 after release; the next request completes normally.
- With AXI_MASTER_TIMEOUT_EN, slave never asserts ar_ready → rw_timeout_o rises 1024 cycles after ar_valid, ar_valid stays high.
